decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 277 +++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: RV32I/RV64I base-integer decoder behind a two-entry (output + skid) elastic buffer.
// Decoded records are registered, so every output field comes straight from a flop.
package alu_enums;
  typedef enum logic [4:0] {
    ALU_NONE  = 5'd0,
    ALU_ADDI  = 5'd1,
    ALU_SLLI  = 5'd2,
    ALU_SLTI  = 5'd3,
    ALU_SLTIU = 5'd4,
    ALU_XORI  = 5'd5,
    ALU_SRLI  = 5'd6,
    ALU_SRAI  = 5'd7,
    ALU_ORI   = 5'd8,
    ALU_ANDI  = 5'd9,
    ALU_ADD   = 5'd10,
    ALU_SUB   = 5'd11,
    ALU_SLL   = 5'd12,
    ALU_SLT   = 5'd13,
    ALU_SLTU  = 5'd14,
    ALU_XOR   = 5'd15,
    ALU_SRL   = 5'd16,
    ALU_SRA   = 5'd17,
    ALU_OR    = 5'd18,
    ALU_AND   = 5'd19
  } alu_op_e;
endpackage

module decode_stage
  import alu_enums::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_dne,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic             rs1_en,
  output logic             rs2_en,
  output logic             rd_wr_en,
  output logic [XLEN-1:0]  imm,
  output logic [SHW-1:0]   shamt,
  output alu_op_e          alu_op,
  output logic [3:0]       op_class,
  output logic [2:0]       funct3,
  output logic [XLEN-1:0]  pc_out,
  output logic             dne_out,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] CLS_NONE   = 4'd0;
  localparam logic [3:0] CLS_ALU    = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_wr_en;
    logic [XLEN-1:0] imm;
    logic [SHW-1:0]  shamt;
    alu_op_e         alu_op;
    logic [3:0]      op_class;
    logic [2:0]      funct3;
    logic [XLEN-1:0] pc;
    logic            dne;
    logic            illegal;
  } dec_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        shift_ok;

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign f7    = in_inst[31:25];
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  // inst[25] is shamt[5] on RV64 but must be zero on RV32
  assign shift_ok = (XLEN == 64) || !in_inst[25];

  dec_t    dec_in;
  logic    legal, r1e, r2e, wre;
  logic [3:0]  cls;
  alu_op_e     aop;
  logic [31:0] imm32;

  always_comb begin
    legal = 1'b1;
    r1e   = 1'b0;
    r2e   = 1'b0;
    wre   = 1'b0;
    cls   = CLS_NONE;
    aop   = ALU_NONE;
    imm32 = '0;
    case (opc)
      OPC_OPIMM: begin
        cls = CLS_ALU; r1e = 1'b1; wre = 1'b1; imm32 = imm_i;
        case (f3)
          3'b000: aop = ALU_ADDI;
          3'b001: begin
            aop   = ALU_SLLI;
            legal = shift_ok && (in_inst[31:26] == 6'b000000);
          end
          3'b010: aop = ALU_SLTI;
          3'b011: aop = ALU_SLTIU;
          3'b100: aop = ALU_XORI;
          3'b101: begin
            aop   = (in_inst[31:26] == 6'b010000) ? ALU_SRAI : ALU_SRLI;
            legal = shift_ok && ((in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000));
          end
          3'b110: aop = ALU_ORI;
          default: aop = ALU_ANDI;
        endcase
      end
      OPC_OP: begin
        cls = CLS_ALU; r1e = 1'b1; r2e = 1'b1; wre = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: aop = ALU_ADD;
            3'b001: aop = ALU_SLL;
            3'b010: aop = ALU_SLT;
            3'b011: aop = ALU_SLTU;
            3'b100: aop = ALU_XOR;
            3'b101: aop = ALU_SRL;
            3'b110: aop = ALU_OR;
            default: aop = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          aop = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          aop = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_LOAD:   begin cls = CLS_LOAD;   r1e = 1'b1; wre = 1'b1; imm32 = imm_i; end
      OPC_STORE:  begin cls = CLS_STORE;  r1e = 1'b1; r2e = 1'b1; imm32 = imm_s; end
      OPC_BRANCH: begin cls = CLS_BRANCH; r1e = 1'b1; r2e = 1'b1; imm32 = imm_b; end
      OPC_JAL:    begin cls = CLS_JAL;    wre = 1'b1; imm32 = imm_j; end
      OPC_JALR: begin
        cls = CLS_JALR; r1e = 1'b1; wre = 1'b1; imm32 = imm_i;
        legal = (f3 == 3'b000);
      end
      OPC_LUI:    begin cls = CLS_LUI;   wre = 1'b1; imm32 = imm_u; end
      OPC_AUIPC:  begin cls = CLS_AUIPC; wre = 1'b1; imm32 = imm_u; end
      default:    legal = 1'b0;
    endcase

    if (!legal || in_dne) begin
      cls = CLS_NONE; aop = ALU_NONE;
      r1e = 1'b0; r2e = 1'b0; wre = 1'b0;
      imm32 = '0;
    end
    wre = wre && (in_inst[11:7] != 5'd0);

    dec_in          = '0;
    dec_in.rs1      = r1e ? in_inst[19:15] : 5'd0;
    dec_in.rs2      = r2e ? in_inst[24:20] : 5'd0;
    dec_in.rd       = wre ? in_inst[11:7]  : 5'd0;
    dec_in.rs1_en   = r1e;
    dec_in.rs2_en   = r2e;
    dec_in.rd_wr_en = wre;
    dec_in.imm      = XLEN'($signed(imm32));
    dec_in.shamt    = in_inst[20 +: SHW];
    dec_in.alu_op   = aop;
    dec_in.op_class = cls;
    dec_in.funct3   = f3;
    dec_in.pc       = in_pc;
    dec_in.dne      = in_dne;
    dec_in.illegal  = !legal && !in_dne;
  end

  dec_t             out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer, out_xfer;

  assign in_ready = !skid_valid_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    // The downstream already consumed this entry, so it is counted even in a flush cycle
    if (out_xfer && !out_q.dne && !out_q.illegal && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_xfer;
        if (in_xfer) out_d = dec_in;
      end
    end else if (in_xfer) begin
      skid_d       = dec_in;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rs1_addr  = out_q.rs1;
  assign rs2_addr  = out_q.rs2;
  assign rd_addr   = out_q.rd;
  assign rs1_en    = out_q.rs1_en;
  assign rs2_en    = out_q.rs2_en;
  assign rd_wr_en  = out_q.rd_wr_en;
  assign imm       = out_q.imm;
  assign shamt     = out_q.shamt;
  assign alu_op    = out_q.alu_op;
  assign op_class  = out_q.op_class;
  assign funct3    = out_q.funct3;
  assign pc_out    = out_q.pc;
  assign dne_out   = out_q.dne;
  assign illegal   = out_q.illegal;
  assign dec_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, skid ordering, flush, async reset and counter saturation.
// A second instance with a 2-bit counter sees the same stimulus to exercise saturation.
module tb_decode_stage;
  import alu_enums::*;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_dne, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, rs1_en, rs2_en, rd_wr_en, dne_out, illegal;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, shamt;
  logic [31:0] imm, pc_out, dec_count;
  logic [3:0]  op_class;
  logic [2:0]  funct3;
  alu_op_e     alu_op;

  logic        s_in_ready, s_out_valid, s_rs1_en, s_rs2_en, s_rd_wr_en, s_dne_out, s_illegal;
  logic [4:0]  s_rs1_addr, s_rs2_addr, s_rd_addr, s_shamt;
  logic [31:0] s_imm, s_pc_out;
  logic [1:0]  s_dec_count;
  logic [3:0]  s_op_class;
  logic [2:0]  s_funct3;
  alu_op_e     s_alu_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .CNT_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc), .in_dne(in_dne),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_wr_en(rd_wr_en),
    .imm(imm), .shamt(shamt), .alu_op(alu_op), .op_class(op_class),
    .funct3(funct3), .pc_out(pc_out), .dne_out(dne_out), .illegal(illegal),
    .dec_count(dec_count)
  );

  decode_stage #(.XLEN(32), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_inst(in_inst), .in_pc(in_pc), .in_dne(in_dne),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr), .rd_addr(s_rd_addr),
    .rs1_en(s_rs1_en), .rs2_en(s_rs2_en), .rd_wr_en(s_rd_wr_en),
    .imm(s_imm), .shamt(s_shamt), .alu_op(s_alu_op), .op_class(s_op_class),
    .funct3(s_funct3), .pc_out(s_pc_out), .dne_out(s_dne_out), .illegal(s_illegal),
    .dec_count(s_dec_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [3:0] cls, input alu_op_e aop,
                         input logic [2:0] en, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [31:0] im, input logic ill);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".class"}, 64'(op_class), 64'(cls));
    chk({tag, ".alu"},   64'(alu_op), 64'(aop));
    chk({tag, ".en"},    64'({rs1_en, rs2_en, rd_wr_en}), 64'(en));
    chk({tag, ".rs1"},   64'(rs1_addr), 64'(r1));
    chk({tag, ".rs2"},   64'(rs2_addr), 64'(r2));
    chk({tag, ".rd"},    64'(rd_addr), 64'(rd));
    chk({tag, ".imm"},   64'(imm), 64'(im));
    chk({tag, ".ill"},   64'(illegal), 64'(ill));
  endtask

  // Called at a negedge; the instruction is captured at the next posedge and visible at the following negedge
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic dne);
    in_inst  = inst;
    in_pc    = pc;
    in_dne   = dne;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_dne = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0;

    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.class",     64'(op_class), 64'd0);
    chk("rst.alu",       64'(alu_op), 64'(ALU_NONE));
    chk("rst.imm",       64'(imm), 64'd0);
    chk("rst.rd_wr_en",  64'(rd_wr_en), 64'd0);
    chk("rst.count",     64'(dec_count), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel.in_ready",  64'(in_ready), 64'd1);
    chk("rel.out_valid", 64'(out_valid), 64'd0);

    out_ready = 1'b1;
    send(32'hFFF08293, 32'h100, 1'b0);
    chk_dec("addi", 4'd1, ALU_ADDI, 3'b101, 5'd1, 5'd0, 5'd5, 32'hFFFFFFFF, 1'b0);
    chk("addi.pc", 64'(pc_out), 64'h100);
    send(32'h0021A423, 32'h104, 1'b0);
    chk_dec("sw", 4'd3, ALU_NONE, 3'b110, 5'd3, 5'd2, 5'd0, 32'd8, 1'b0);
    chk("sw.f3", 64'(funct3), 64'd2);
    @(negedge clk);
    chk("idle1.out_valid", 64'(out_valid), 64'd0);
    chk("idle1.count",     64'(dec_count), 64'd2);
    chk("idle1.satcount",  64'(s_dec_count), 64'd2);

    send(32'h4000D093, 32'h108, 1'b0);
    chk_dec("srai0", 4'd1, ALU_SRAI, 3'b101, 5'd1, 5'd0, 5'd1, 32'h400, 1'b0);
    chk("srai0.shamt", 64'(shamt), 64'd0);
    send(32'h4010D093, 32'h10C, 1'b0);
    chk_dec("srai1", 4'd1, ALU_SRAI, 3'b101, 5'd1, 5'd0, 5'd1, 32'h401, 1'b0);
    chk("srai1.shamt", 64'(shamt), 64'd1);
    send(32'h4200D093, 32'h110, 1'b0);
    chk_dec("srai_b25", 4'd0, ALU_NONE, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    send(32'h123451B7, 32'h114, 1'b0);
    chk_dec("lui", 4'd7, ALU_NONE, 3'b001, 5'd0, 5'd0, 5'd3, 32'h12345000, 1'b0);
    send(32'h40208033, 32'h118, 1'b0);
    chk_dec("sub_x0", 4'd1, ALU_SUB, 3'b110, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0);
    send(32'h402091B3, 32'h11C, 1'b0);
    chk_dec("f7_bad", 4'd0, ALU_NONE, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    send(32'h008000EF, 32'h120, 1'b0);
    chk_dec("jal", 4'd5, ALU_NONE, 3'b001, 5'd0, 5'd0, 5'd1, 32'd8, 1'b0);
    send(32'h000090E7, 32'h124, 1'b0);
    chk_dec("jalr_f3", 4'd0, ALU_NONE, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    send(32'hFE000EE3, 32'h128, 1'b0);
    chk_dec("beq", 4'd4, ALU_NONE, 3'b110, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0);
    send(32'hFFF08293, 32'h1234, 1'b1);
    chk_dec("dne", 4'd0, ALU_NONE, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    chk("dne.flag", 64'(dne_out), 64'd1);
    chk("dne.pc",   64'(pc_out), 64'h1234);
    in_dne = 1'b0;
    @(negedge clk);
    chk("idle2.count",    64'(dec_count), 64'd8);
    chk("idle2.satcount", 64'(s_dec_count), 64'd3);

    // Stalled output: A to output, B to skid, C refused until the skid drains
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF08293; in_pc = 32'h200;
    @(negedge clk);
    chk("stall.a_out",    64'(pc_out), 64'h200);
    chk("stall.in_ready1", 64'(in_ready), 64'd1);
    in_inst = 32'h123451B7; in_pc = 32'h204;
    @(negedge clk);
    chk("stall.in_ready2", 64'(in_ready), 64'd0);
    chk("stall.hold_pc1",  64'(pc_out), 64'h200);
    in_inst = 32'h0021A423; in_pc = 32'h208;
    @(negedge clk);
    chk("stall.in_ready3", 64'(in_ready), 64'd0);
    chk("stall.hold_pc2",  64'(pc_out), 64'h200);
    chk("stall.hold_alu",  64'(alu_op), 64'(ALU_ADDI));
    chk("stall.hold_imm",  64'(imm), 64'hFFFFFFFF);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain.b_pc",     64'(pc_out), 64'h204);
    chk("drain.b_class",  64'(op_class), 64'd7);
    chk("drain.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain.c_pc",    64'(pc_out), 64'h208);
    chk("drain.c_class", 64'(op_class), 64'd3);
    @(negedge clk);
    chk("drain.empty", 64'(out_valid), 64'd0);
    chk("drain.count", 64'(dec_count), 64'd11);

    // Flush with both entries full and a new input pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF08293; in_pc = 32'h300;
    @(negedge clk);
    in_inst = 32'h008000EF; in_pc = 32'h304;
    @(negedge clk);
    chk("full.in_ready",  64'(in_ready), 64'd0);
    chk("full.out_valid", 64'(out_valid), 64'd1);
    flush = 1'b1; in_inst = 32'hFE000EE3; in_pc = 32'h308;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.in_ready",  64'(in_ready), 64'd1);
    chk("flush.count",     64'(dec_count), 64'd11);

    // An input accepted in the flush cycle is dropped
    out_ready = 1'b1;
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'hFFF08293; in_pc = 32'h400;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flushin.out_valid", 64'(out_valid), 64'd0);
    chk("flushin.in_ready",  64'(in_ready), 64'd1);
    @(negedge clk);
    chk("flushin.count", 64'(dec_count), 64'd11);

    // Asynchronous reset between clock edges with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF08293; in_pc = 32'h500;
    @(negedge clk);
    in_inst = 32'h123451B7; in_pc = 32'h504;
    @(negedge clk);
    in_valid = 1'b0;
    chk("prerst.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.in_ready",  64'(in_ready), 64'd1);
    chk("arst.count",     64'(dec_count), 64'd0);
    chk("arst.satcount",  64'(s_dec_count), 64'd0);
    chk("arst.class",     64'(op_class), 64'd0);
    chk("arst.alu",       64'(alu_op), 64'(ALU_NONE));
    chk("arst.pc",        64'(pc_out), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
